// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer slice: data/opcode widths,
// shift opcodes, sequencer states and small opcode helpers.
package shift_sequencer_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned OP_WIDTH    = 2;
  localparam int unsigned SHAMT_WIDTH = 5;

  typedef enum logic [OP_WIDTH-1:0] {
    SHIFT_OP_SLL = 2'b00,
    SHIFT_OP_SRL = 2'b01,
    SHIFT_OP_ROL = 2'b10,
    SHIFT_OP_ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PASS1 = 2'b01,
    PASS2 = 2'b10,
    DONE  = 2'b11
  } state_e;

  function automatic logic is_rotate(input shift_op_e op);
    return (op == SHIFT_OP_ROL) || (op == SHIFT_OP_ROR);
  endfunction

  // Direction of the first shifter pass: left for SLL and ROL.
  function automatic logic pass1_left(input shift_op_e op);
    return (op == SHIFT_OP_SLL) || (op == SHIFT_OP_ROL);
  endfunction

  // Second rotate pass shifts the other way by the complementary amount.
  function automatic logic [DATA_WIDTH-1:0] rot_complement(input logic [SHAMT_WIDTH-1:0] sh);
    logic [SHAMT_WIDTH:0] amt;
    amt = (SHAMT_WIDTH+1)'(DATA_WIDTH) - {1'b0, sh};
    return DATA_WIDTH'(amt);
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result bus of the shift sequencer.
//   REQn_VALID/READY/OP/D/S : two requester channels (n = 0,1)
//   RES_VALID/READY/DATA/ID : result channel with owning requester index
//   BUSY                    : sequencer not idle
// master = requesters + result consumer, slave = the sequencer.
interface shift_sequencer_if;
  import shift_sequencer_pkg::*;

  logic                  REQ0_VALID;
  logic                  REQ0_READY;
  logic [OP_WIDTH-1:0]   REQ0_OP;
  logic [DATA_WIDTH-1:0] REQ0_D;
  logic [DATA_WIDTH-1:0] REQ0_S;

  logic                  REQ1_VALID;
  logic                  REQ1_READY;
  logic [OP_WIDTH-1:0]   REQ1_OP;
  logic [DATA_WIDTH-1:0] REQ1_D;
  logic [DATA_WIDTH-1:0] REQ1_S;

  logic                  RES_VALID;
  logic                  RES_READY;
  logic [DATA_WIDTH-1:0] RES_DATA;
  logic                  RES_ID;

  logic                  BUSY;

  modport master (
    output REQ0_VALID, REQ0_OP, REQ0_D, REQ0_S,
    output REQ1_VALID, REQ1_OP, REQ1_D, REQ1_S,
    output RES_READY,
    input  REQ0_READY, REQ1_READY,
    input  RES_VALID, RES_DATA, RES_ID, BUSY
  );

  modport slave (
    input  REQ0_VALID, REQ0_OP, REQ0_D, REQ0_S,
    input  REQ1_VALID, REQ1_OP, REQ1_D, REQ1_S,
    input  RES_READY,
    output REQ0_READY, REQ1_READY,
    output RES_VALID, RES_DATA, RES_ID, BUSY
  );

endinterface

// File: rtl/SHIFT32.sv
// 32-bit logical barrel shifter.
//   Y   out 32 : shifted result
//   D   in  32 : operand
//   S   in  32 : shift amount; any amount >= 32 yields 0
//   LnR in  1  : 1 = shift left, 0 = shift right (zero fill)
module SHIFT32 (
  output logic [31:0] Y,
  input  logic [31:0] D,
  input  logic [31:0] S,
  input  logic        LnR
);

  always_comb begin
    Y = '0;
    if (S[31:5] == '0) begin
      Y = LnR ? (D << S[4:0]) : (D >> S[4:0]);
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Shares one SHIFT32 between two requesters with round-robin arbitration and
// sequences each op as one (SLL/SRL, zero rotate) or two (rotate) shifter
// passes, OR-ing the pass results for rotates.
//   CLK : clock, rising edge
//   RST : asynchronous active-low reset
//   bus : request channels, result channel and BUSY (slave side)
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  shift_sequencer_if.slave  bus
);

  state_e                state_q, state_d;
  shift_op_e             op_q, op_d;
  logic [DATA_WIDTH-1:0] d_q, d_d;
  logic [DATA_WIDTH-1:0] s_q, s_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  id_q, id_d;
  logic                  last_gnt_q, last_gnt_d;

  logic                  gnt;
  logic                  gnt_valid;
  logic                  ready0, ready1;

  logic [DATA_WIDTH-1:0] sh_d, sh_s, sh_y;
  logic                  sh_lnr;

  SHIFT32 u_shift32 (
    .Y   (sh_y),
    .D   (sh_d),
    .S   (sh_s),
    .LnR (sh_lnr)
  );

  // Round-robin: contention goes to the requester not granted last time.
  always_comb begin
    gnt = ~last_gnt_q;
    if (bus.REQ0_VALID && bus.REQ1_VALID) begin
      gnt = ~last_gnt_q;
    end else if (bus.REQ1_VALID) begin
      gnt = 1'b1;
    end else if (bus.REQ0_VALID) begin
      gnt = 1'b0;
    end
    gnt_valid = gnt ? bus.REQ1_VALID : bus.REQ0_VALID;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    d_d        = d_q;
    s_d        = s_q;
    acc_d      = acc_q;
    id_d       = id_q;
    last_gnt_d = last_gnt_q;
    ready0     = 1'b0;
    ready1     = 1'b0;
    sh_d       = '0;
    sh_s       = '0;
    sh_lnr     = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready0 = ~gnt;
        ready1 = gnt;
        if (gnt_valid) begin
          op_d       = shift_op_e'(gnt ? bus.REQ1_OP : bus.REQ0_OP);
          d_d        = gnt ? bus.REQ1_D : bus.REQ0_D;
          s_d        = gnt ? bus.REQ1_S : bus.REQ0_S;
          id_d       = gnt;
          last_gnt_d = gnt;
          state_d    = PASS1;
        end
      end

      PASS1: begin
        sh_d   = d_q;
        sh_lnr = pass1_left(op_q);
        // Rotates only honour the low five bits of the amount.
        if (is_rotate(op_q)) begin
          sh_s = DATA_WIDTH'(s_q[SHAMT_WIDTH-1:0]);
        end else begin
          sh_s = s_q;
        end
        acc_d = sh_y;
        if (is_rotate(op_q) && (s_q[SHAMT_WIDTH-1:0] != '0)) begin
          state_d = PASS2;
        end else begin
          state_d = DONE;
        end
      end

      PASS2: begin
        sh_d    = d_q;
        sh_s    = rot_complement(s_q[SHAMT_WIDTH-1:0]);
        sh_lnr  = ~pass1_left(op_q);
        acc_d   = acc_q | sh_y;
        state_d = DONE;
      end

      DONE: begin
        if (bus.RES_READY) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      op_q       <= SHIFT_OP_SLL;
      d_q        <= '0;
      s_q        <= '0;
      acc_q      <= '0;
      id_q       <= 1'b0;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      d_q        <= d_d;
      s_q        <= s_d;
      acc_q      <= acc_d;
      id_q       <= id_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  assign bus.REQ0_READY = ready0;
  assign bus.REQ1_READY = ready1;
  assign bus.RES_VALID  = (state_q == DONE);
  assign bus.RES_DATA   = acc_q;
  assign bus.RES_ID     = id_q;
  assign bus.BUSY       = (state_q != IDLE);

endmodule
